// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : apb_pkg
//  Purpose  : Shared types and constants for the round-robin APB master.
//  Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Encoding carried on rsp_err alongside rsp_valid
    localparam logic c_rsp_ok      = 1'b0;
    localparam logic c_rsp_timeout = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : apb_rr_arbiter
//  Purpose  : Combinational round-robin pick; searches from last+1 upward.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] w_cand;

    // Walk from the farthest candidate to the nearest so the nearest hit wins
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (req[w_cand]) begin
                grant     = NUM_REQ'(1) << w_cand;
                grant_idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_rr_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_rr_master
//  Purpose  : Shares one APB bus between NUM_REQ requesters, round-robin,
//             with PREADY wait states and an ACCESS-phase timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_rr_master
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [DATA_W-1:0]         PRDATA,
    input  logic                      PREADY
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e       r_state;
    apb_state_e       w_state_nxt;
    logic [IDX_W-1:0] r_last;
    logic [CNT_W-1:0] r_wait_cnt;

    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_timeout;
    logic               w_done;
    logic               w_arb;
    logic               w_take;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .last      (r_last),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (r_state == ACCESS) && !PREADY &&
                               (r_wait_cnt == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    assign w_done    = (r_state == ACCESS) && (PREADY || w_timeout);
    assign w_arb     = (r_state == IDLE) || w_done;
    assign w_take    = w_arb && (|req_valid);
    assign req_ready = w_arb ? w_grant : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_take) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (w_done) w_state_nxt = w_take ? SETUP : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus phase flags follow the next state so they are registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PADDR      <= '0;
            PWRITE     <= 1'b0;
            PWDATA     <= '0;
            r_last     <= IDX_W'(NUM_REQ - 1);
            r_wait_cnt <= '0;
            rsp_valid  <= '0;
            rsp_err    <= c_rsp_ok;
            rsp_rdata  <= '0;
        end else begin
            PSEL    <= (w_state_nxt != IDLE);
            PENABLE <= (w_state_nxt == ACCESS);

            if (w_take) begin
                r_last <= w_grant_idx;
                PADDR  <= req_addr[w_grant_idx*ADDR_W +: ADDR_W];
                PWDATA <= req_wdata[w_grant_idx*DATA_W +: DATA_W];
                PWRITE <= req_write[w_grant_idx];
            end

            // Only a stalled ACCESS that stays in ACCESS keeps counting
            if ((r_state == ACCESS) && (w_state_nxt == ACCESS)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end

            rsp_valid <= '0;
            rsp_err   <= c_rsp_ok;
            rsp_rdata <= '0;
            if (w_done) begin
                rsp_valid <= NUM_REQ'(1) << r_last;
                rsp_err   <= PREADY ? c_rsp_ok : c_rsp_timeout;
                if (PREADY && !PWRITE) begin
                    rsp_rdata <= PRDATA;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_rr_master
//  Purpose  : Bench for apb_rr_master: directed scenarios plus random traffic
//             against a transaction-level model with a memory-backed slave.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_rr_master;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid, req_write, req_ready, rsp_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0]         rsp_rdata, PWDATA, PRDATA;
    logic                      rsp_err, PWRITE, PSEL, PENABLE, PREADY;
    logic [ADDR_W-1:0]         PADDR;

    apb_rr_master #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester intent
    bit   [NUM_REQ-1:0] s_valid, s_write;
    logic [31:0]        s_addr  [NUM_REQ];
    logic [31:0]        s_wdata [NUM_REQ];

    // Slave behaviour: 0 ready, 1 mostly ready, 2 fixed stalls, 3 stuck, 4 mostly stalled
    int pready_mode;
    int stall_n, stall_cnt;
    logic [31:0] slave_mem [16];
    logic [31:0] model_mem [16];

    // Transaction model: elapsed cycles since acceptance drive the bus phases
    bit                 m_busy;
    int                 m_cyc, m_owner, m_last;
    logic               m_wr;
    logic [31:0]        m_addr, m_wdata;
    logic [NUM_REQ-1:0] m_rsp_valid;
    logic               m_rsp_err;
    logic [31:0]        m_rsp_rdata;

    logic [NUM_REQ-1:0] ob_ready, ob_rsp_valid;
    logic               ob_rsp_err, ob_psel, ob_pen;
    logic [31:0]        ob_rdata;
    int cyc_no, pen_count;
    int grant_log[$];
    int grant_time[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc_no);
        end
    endtask

    function automatic int log_at(input int i);
        return (i < grant_log.size()) ? grant_log[i] : -1;
    endfunction

    function automatic int time_at(input int i);
        return (i < grant_time.size()) ? grant_time[i] : -100;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_cyc = 0; m_owner = 0; m_last = NUM_REQ - 1;
        m_wr = 0; m_addr = '0; m_wdata = '0;
        m_rsp_valid = '0; m_rsp_err = 0; m_rsp_rdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        s_valid = '0;
        req_valid = '0;
        PREADY = 1'b0;
        PRDATA = '0;
        #1;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_pwrite", PWRITE, 0);
        chk("rst_req_ready", req_ready, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic step();
        int  g;
        bit  done, arb;
        logic [NUM_REQ-1:0] exp_ready;
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = s_valid[i];
            req_write[i] = s_write[i];
            req_addr[i*ADDR_W +: ADDR_W]  = s_addr[i];
            req_wdata[i*DATA_W +: DATA_W] = s_wdata[i];
        end
        PRDATA = slave_mem[PADDR[3:0]];
        case (pready_mode)
            0: PREADY = 1'b1;
            1: PREADY = ($urandom_range(3) != 0);
            2: begin
                if (PENABLE && stall_cnt < stall_n) begin
                    PREADY = 1'b0;
                    stall_cnt++;
                end else begin
                    PREADY = 1'b1;
                    if (PENABLE) stall_cnt = 0;
                end
            end
            3: PREADY = 1'b0;
            default: PREADY = ($urandom_range(19) == 0);
        endcase
        #1;
        done = m_busy && (m_cyc >= 2) && (PREADY || (TIMEOUT > 0 && (m_cyc - 1) == TIMEOUT));
        arb  = !m_busy || done;
        g = -1;
        if (arb) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (m_last + k) % NUM_REQ;
                if (g < 0 && s_valid[c]) g = c;
            end
        end
        exp_ready = (g >= 0) ? (NUM_REQ'(1) << g) : '0;

        chk("req_ready", req_ready, exp_ready);
        chk("psel", PSEL, m_busy);
        chk("penable", PENABLE, m_busy && m_cyc >= 2);
        chk("paddr", PADDR, m_addr);
        chk("pwrite", PWRITE, m_wr);
        chk("pwdata", PWDATA, m_wdata);
        chk("rsp_valid", rsp_valid, m_rsp_valid);
        chk("rsp_err", rsp_err, m_rsp_err);
        chk("rsp_rdata", rsp_rdata, m_rsp_rdata);

        ob_ready = req_ready; ob_rsp_valid = rsp_valid; ob_rsp_err = rsp_err;
        ob_rdata = rsp_rdata; ob_psel = PSEL; ob_pen = PENABLE;
        if (req_ready != '0) begin
            grant_log.push_back($clog2(req_ready));
            grant_time.push_back(cyc_no);
        end
        if (PENABLE) pen_count++;
        if (PSEL && PENABLE && PREADY && PWRITE) slave_mem[PADDR[3:0]] = PWDATA;

        m_rsp_valid = '0; m_rsp_err = 0; m_rsp_rdata = '0;
        if (done) begin
            m_rsp_valid = NUM_REQ'(1) << m_owner;
            m_rsp_err   = !PREADY;
            if (PREADY) begin
                if (m_wr) model_mem[m_addr[3:0]] = m_wdata;
                else      m_rsp_rdata = model_mem[m_addr[3:0]];
            end
        end
        if (g >= 0) begin
            m_busy = 1; m_cyc = 1; m_owner = g; m_last = g;
            m_wr = s_write[g]; m_addr = s_addr[g]; m_wdata = s_wdata[g];
            s_valid[g] = 1'b0;
        end else if (done) begin
            m_busy = 0;
        end else if (m_busy) begin
            m_cyc++;
        end
        cyc_no++;
        @(posedge clk);
    endtask

    task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
        s_valid[i] = 1'b1; s_write[i] = wr; s_addr[i] = a; s_wdata[i] = d;
    endtask

    task automatic random_traffic(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!s_valid[i]) begin
                    if ($urandom_range(3) == 0) set_req(i, 1'($urandom_range(1)), $urandom(), $urandom());
                end else if ($urandom_range(15) == 0) begin
                    s_valid[i] = 1'b0;
                end
            end
            step();
        end
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PREADY = 1'b0; PRDATA = '0;
        s_valid = '0; s_write = '0;
        for (int i = 0; i < NUM_REQ; i++) begin s_addr[i] = '0; s_wdata[i] = '0; end
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 32'h1000_0000 + i;
            model_mem[i] = 32'h1000_0000 + i;
        end
        cyc_no = 0; pen_count = 0; stall_n = 0; stall_cnt = 0;
        pready_mode = 0;
        model_reset();
        apply_reset();

        // Write then read from requester 1, zero wait states
        set_req(1, 1'b1, 32'h0, 32'hDEAD_BEEF);
        step(); chk("t1_grant", ob_ready, 4'b0010);
        step(); chk("t1_setup", {ob_psel, ob_pen}, 2'b10);
        step(); chk("t1_access", {ob_psel, ob_pen}, 2'b11);
        step(); chk("t1_rsp", ob_rsp_valid, 4'b0010); chk("t1_err", ob_rsp_err, 0);
        set_req(1, 1'b0, 32'h0, 32'h0);
        repeat (4) step();
        chk("t1_rd_rsp", ob_rsp_valid, 4'b0010);
        chk("t1_rdata", ob_rdata, 32'hDEAD_BEEF);

        // Simultaneous 0 and 2 from reset
        apply_reset();
        grant_log.delete(); grant_time.delete();
        set_req(0, 1'b0, 32'h1, 32'h0);
        set_req(2, 1'b0, 32'h2, 32'h0);
        repeat (6) step();
        chk("t2_count", grant_log.size(), 2);
        chk("t2_first", log_at(0), 0);
        chk("t2_second", log_at(1), 2);

        // All four held continuously from reset
        apply_reset();
        grant_log.delete(); grant_time.delete();
        repeat (12) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!s_valid[i]) set_req(i, 1'($urandom_range(1)), $urandom(), $urandom());
            step();
        end
        chk("t3_g0", log_at(0), 0);
        chk("t3_g1", log_at(1), 1);
        chk("t3_g2", log_at(2), 2);
        chk("t3_g3", log_at(3), 3);
        chk("t3_g4", log_at(4), 0);
        for (int k = 0; k < 4; k++) chk("t3_spacing", time_at(k + 1) - time_at(k), 2);

        // Three wait states
        s_valid = '0;
        repeat (4) step();
        pready_mode = 2; stall_n = 3; stall_cnt = 0; pen_count = 0;
        set_req(3, 1'b0, 32'h5, 32'h0);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (ob_rsp_valid != '0) seen = 1;
        end
        chk("t4_rsp_seen", seen, 1);
        chk("t4_rsp_who", ob_rsp_valid, 4'b1000);
        chk("t4_penable_cycles", pen_count, 4);

        // PREADY stuck: timeout after exactly TIMEOUT ACCESS cycles
        pready_mode = 3; pen_count = 0;
        set_req(2, 1'b1, 32'h7, 32'hCAFE_F00D);
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            step();
            if (ob_rsp_valid != '0) seen = 1;
        end
        chk("t5_rsp_seen", seen, 1);
        chk("t5_rsp_who", ob_rsp_valid, 4'b0100);
        chk("t5_err", ob_rsp_err, 1);
        chk("t5_rdata", ob_rdata, 0);
        chk("t5_penable_cycles", pen_count, 16);
        chk("t5_bus_idle", ob_psel, 0);
        pready_mode = 0;
        set_req(0, 1'b0, 32'h7, 32'h0);
        repeat (4) step();
        chk("t5_next_rsp", ob_rsp_valid, 4'b0001);
        chk("t5_next_err", ob_rsp_err, 0);
        chk("t5_next_rdata", ob_rdata, 32'h1000_0007);

        // Reset during ACCESS
        pready_mode = 3;
        set_req(1, 1'b0, 32'h3, 32'h0);
        repeat (4) step();
        chk("t6_in_access", {ob_psel, ob_pen}, 2'b11);
        apply_reset();
        pready_mode = 0;
        set_req(2, 1'b0, 32'h4, 32'h0);
        set_req(0, 1'b0, 32'h6, 32'h0);
        step();
        chk("t6_first_after_rst", ob_ready, 4'b0001);
        repeat (6) step();

        // Random traffic, light then heavy stalling
        pready_mode = 1;
        random_traffic(800);
        pready_mode = 4;
        random_traffic(800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/apb_rr_master.md
# apb_rr_master

Round-robin APB master that shares one APB bus between `NUM_REQ` local requesters. Each requester issues single read/write transactions over a valid/ready command port and receives a one-cycle response pulse. The block sits between internal initiators (CPU bridge, DMA, debug port) and APB peripherals such as our single-register APB slave. It sequences SETUP/ACCESS phases, honours PREADY wait states and aborts hung transfers with a timeout.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8)
- `ADDR_W`, 32: APB address width
- `DATA_W`, 32: APB data width
- `TIMEOUT`, 16: maximum ACCESS cycles before abort; 0 disables the timeout
- `clk`  in  1  clock; all logic on its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NUM_REQ  per-requester command valid
- `req_write`  in  NUM_REQ  per-requester direction, 1 = write
- `req_addr`  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
- `req_wdata`  in  NUM_REQ*DATA_W  flattened write data
- `req_ready`  out  NUM_REQ  one-hot grant/accept, combinational
- `rsp_valid`  out  NUM_REQ  one-hot completion pulse, registered
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and on error
- `rsp_err`  out  1  qualifies `rsp_valid`: transfer aborted by timeout
- `PADDR`, `PWRITE`, `PWDATA`  out  ADDR_W/1/DATA_W  APB command, registered
- `PSEL`, `PENABLE`  out  1  APB phase control, registered
- `PRDATA`  in  DATA_W  APB read data
- `PREADY`  in  1  APB ready

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset state is IDLE.
- **Arbitration point:** IDLE, or ACCESS in its completing cycle (PREADY=1 or timeout).
  - At an arbitration point with any `req_valid` set, pick the first index with `req_valid` set, searching from `last+1` modulo NUM_REQ.
  - Assert `req_ready[g]` in that same cycle.
  - Latch addr, wdata and write for requester g, set `last <= g`, and go to SETUP.
- `req_ready` is never asserted outside an arbitration point.
- Handshake is `req_valid & req_ready`. Requesters hold their fields stable until accepted. Dropping `req_valid` before acceptance is legal (withdraw).
- **SETUP:** PSEL=1, PENABLE=0, command on PADDR/PWRITE/PWDATA. Always lasts one cycle, then ACCESS.
- **ACCESS:** PSEL=1, PENABLE=1, command held stable. The wait counter increments each cycle that PREADY=0.
- **Normal completion** (PREADY=1): next cycle `rsp_valid[g]=1`, `rsp_err=0`, `rsp_rdata = PRDATA` (read) or 0 (write).
- **Timeout** (TIMEOUT>0, PREADY=0 with counter == TIMEOUT-1): abort. Next cycle `rsp_valid[g]=1`, `rsp_err=1`, `rsp_rdata=0`.
  - PREADY=1 on that same cycle wins and counts as normal completion.
- **After completion or abort:** go to SETUP if a new grant was made, else IDLE, where PSEL=0 and PENABLE=0. PADDR/PWRITE/PWDATA keep their last value.
- `rsp_valid`, `rsp_err` and `rsp_rdata` are valid for exactly one cycle. `rsp_rdata` returns to 0 afterwards.
- `last` resets to NUM_REQ-1, so requester 0 has first priority after reset.

## Timing
- Reset values: all outputs 0, FSM IDLE, wait counter 0.
- Reset mid-transfer: APB is released asynchronously (PSEL=PENABLE=0). The in-flight request is dropped with no `rsp_valid`.
- Latency with zero wait states: accept at cycle 0 → SETUP at 1 → ACCESS at 2 → `rsp_valid` at 3.
- Each PREADY wait state adds one cycle.
- Back-to-back throughput: one transfer per 2 cycles (ACCESS → SETUP directly, no IDLE gap).
- A completion's `rsp_valid` and the next grant's SETUP phase occur in the same cycle.

## Structure
- Package `apb_pkg`:
  - `apb_state_e` enum {IDLE, SETUP, ACCESS}
  - `APB_ADDR_W` = 32, `APB_DATA_W` = 32 defaults
  - Response-error encoding constant
- Sub-module `apb_rr_arbiter`:
  - Inputs: request vector, `last` pointer
  - Outputs: one-hot grant and encoded index
  - Purely combinational; `last` is held in the parent.

## Test plan
- Single write then read from requester 1 against the single-register slave (PREADY tied 1): write 0xDEADBEEF at 0x0 → `rsp_valid[1]` at cycle 3, `rsp_err=0`; read → `rsp_rdata=0xDEADBEEF`.
- Requesters 0 and 2 assert simultaneously from reset → order 0, 2. Then 0, 1, 2, 3 held continuously → grants rotate 0,1,2,3,0; APB SETUP every 2 cycles.
- Slave holds PREADY=0 for 3 ACCESS cycles → PENABLE high 4 cycles, PADDR stable, `rsp_valid` 1 cycle after PREADY.
- PREADY stuck 0 with TIMEOUT=16 → exactly 16 ACCESS cycles, then `rsp_err=1`, `rsp_rdata=0`, bus idle, next request served normally.
- `rst_n` low during ACCESS → PSEL/PENABLE fall immediately, no `rsp_valid`. After release, requester 0 wins first.
